fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of FIFO words and stream data.
REQ-002 Parameter PKT_LEN, default 16, words per packet; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  when high, block may issue FIFO reads; when low, no new reads issue.
REQ-006 empty  input  1  FIFO empty flag from syn_fifo.
REQ-007 read_en  output  1  FIFO read strobe to syn_fifo.
REQ-008 fifo_data  input  DATA_WIDTH  syn_fifo data_out, valid the cycle after an accepted read.
REQ-009 out_valid  output  1  stream word available.
REQ-010 out_ready  input  1  downstream accepts word when high with out_valid.
REQ-011 out_data  output  DATA_WIDTH  stream word, oldest buffered word first.
REQ-012 out_last  output  1  high with the word that completes a PKT_LEN-word packet.
REQ-013 word_count  output  16  total words delivered downstream since reset, wraps modulo 2^16.

Function
REQ-014 Accepted read SHALL be a cycle with read_en=1 and empty=0; read_en SHALL never be 1 while empty=1.
REQ-015 Block SHALL hold an internal 2-entry buffer; occupancy occ in 0..2, in-flight flag inf set the cycle after an accepted read.
REQ-016 read_en SHALL be 1 iff en=1, empty=0 and (occ + inf + pending read) < 2, counting a same-cycle downstream transfer as freeing one slot.
REQ-017 Word returned on fifo_data SHALL be captured in the buffer on the cycle following the accepted read; no captured word SHALL be dropped or duplicated.
REQ-018 Transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; occ decrements by one per transfer.
REQ-019 out_valid SHALL equal (occ>0); out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 Simultaneous capture and transfer SHALL leave occ unchanged and preserve word order.
REQ-021 With en=1, FIFO non-empty and out_ready held 1, sustained throughput SHALL be one word per clock after initial 2-cycle latency (read_en to out_valid).
REQ-022 Packet counter pkt_idx (0..PKT_LEN-1) SHALL increment per transfer and wrap to 0 after PKT_LEN-1; out_last SHALL be 1 iff out_valid=1 and pkt_idx=PKT_LEN-1.
REQ-023 PKT_LEN=1 SHALL assert out_last on every valid word.
REQ-024 word_count SHALL increment by one per transfer, 16'hFFFF wrapping to 16'h0000.
REQ-025 Deasserting en SHALL stop new reads the same cycle; in-flight and buffered words SHALL still be captured and delivered.
REQ-026 FIFO going empty mid-stream SHALL drop read_en with no bubble-induced data loss; streaming resumes when empty=0.

Reset
REQ-027 rst=0 SHALL asynchronously force read_en=0, out_valid=0, out_last=0, out_data=0, word_count=0, occ=0, inf=0, pkt_idx=0.
REQ-028 Reset asserted mid-packet or with words buffered/in flight SHALL discard them; first transfer after release starts a new packet (pkt_idx=0).
REQ-029 After rst release, first read_en SHALL be no earlier than the first rising edge with rst=1.

Verification
REQ-030 FIFO preloaded with 17 words 0x01..0x11, en=1, out_ready=1 -> read_en 17 cycles, out_data 0x01..0x11 in order, out_last only on 0x10, word_count=17.
REQ-031 Same preload, out_ready toggling 1,0,1,0 -> no read_en while occ+inf=2, out_data stable during stalls, all 17 words in order, none duplicated.
REQ-032 en dropped one cycle after first accepted read -> exactly the in-flight words (≤2) delivered, then out_valid=0, read_en=0 until en=1.
REQ-033 rst pulsed low with occ=2 and pkt_idx=5 -> outputs zero immediately; after release, next delivered word has pkt_idx=0, word_count counts from 1.
REQ-034 PKT_LEN=1, 3 words -> out_last=1 on all 3; 65537 words streamed with PKT_LEN=16 -> word_count=1.
REQ-035 empty held 1, en=1 -> read_en stays 0 indefinitely, out_valid=0.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Pulls words from a syn_fifo-style FIFO (1-cycle read latency) into a 2-entry
// skid buffer and presents them as a valid/ready stream with packet framing.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  empty,
  output logic                  read_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [15:0]           word_count
);
  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  logic [1:0]            occ;
  logic                  inf;
  logic                  run;
  logic [DATA_WIDTH-1:0] ent0, ent1;
  logic [15:0]           pkt_idx;
  logic                  xfer;
  logic [2:0]            committed;

  assign out_valid = (occ != 2'd0);
  assign out_data  = ent0;
  assign out_last  = out_valid && (pkt_idx == LAST_IDX);
  assign xfer      = out_valid && out_ready;

  // Slots still owed after this cycle; a read is allowed only if one remains free.
  assign committed = {1'b0, occ} + {2'b00, inf} - {2'b00, xfer};
  assign read_en   = rst && run && en && !empty && (committed < 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run        <= 1'b0;
      inf        <= 1'b0;
      occ        <= 2'd0;
      ent0       <= '0;
      ent1       <= '0;
      pkt_idx    <= 16'd0;
      word_count <= 16'd0;
    end else begin
      run <= 1'b1;
      inf <= read_en;
      case ({inf, xfer})
        2'b10: begin
          if (occ == 2'd0) ent0 <= fifo_data;
          else             ent1 <= fifo_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Capture lands behind whatever remains after the head leaves.
          if (occ == 2'd1) ent0 <= fifo_data;
          else begin
            ent0 <= ent1;
            ent1 <= fifo_data;
          end
        end
        default: ;
      endcase
      if (xfer) begin
        word_count <= word_count + 16'd1;
        pkt_idx    <= (pkt_idx == LAST_IDX) ? 16'd0 : pkt_idx + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench: FIFO model feeds the DUT, scoreboard checks the stream.
module tb_fifo_rd_stream;
  localparam int W   = 8;
  localparam int PKT = 16;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, empty = 1'b1, out_ready = 1'b0;
  logic [W-1:0] fifo_data = '0;
  logic read_en, out_valid, out_last;
  logic [W-1:0] out_data;
  logic [15:0] word_count;
  logic re1, ov1, ol1;
  logic [W-1:0] od1;
  logic [15:0] wc1;

  fifo_rd_stream #(.DATA_WIDTH(W), .PKT_LEN(PKT)) dut (
    .clk(clk), .rst(rst), .en(en), .empty(empty), .read_en(read_en),
    .fifo_data(fifo_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .word_count(word_count));

  fifo_rd_stream #(.DATA_WIDTH(W), .PKT_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .empty(empty), .read_en(re1),
    .fifo_data(fifo_data), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_last(ol1), .word_count(wc1));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [W-1:0] fifo_q[$], exp_q[$];
  int acc_total = 0, xfer_total = 0, refill_n = 0, rmode = 0, last_cycles = 0;
  bit acc_prev = 0, pop_req = 0, run_m = 0, prev_stall = 0, prev_last = 0, emode = 0;
  logic [W-1:0] prev_data = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / reference model: words owed = accepted reads - transfers.
  initial forever begin
    int outstanding, xn;
    logic [W-1:0] e;
    @(negedge clk);
    if (!rst) begin
      chk("rst_read_en", read_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_word_count", word_count, 0);
      exp_q.delete();
      acc_total = 0; xfer_total = 0; acc_prev = 0; prev_stall = 0; pop_req = 0;
    end else begin
      xn = (out_valid && out_ready) ? 1 : 0;
      outstanding = acc_total - xfer_total;
      chk("read_en", read_en, run_m && en && !empty && (outstanding - xn) < 2);
      chk("out_valid", out_valid, (outstanding - int'(acc_prev)) > 0);
      chk("pl1_last", ol1, ov1);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (xn != 0) begin
        if (exp_q.size() == 0) chk("xfer_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
          chk("out_last", out_last, (xfer_total % PKT) == PKT - 1);
          chk("word_count", word_count, 32'(xfer_total[15:0]));
          xfer_total++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (read_en && empty) chk("read_while_empty", 1, 0);
      if (read_en && !empty) begin
        exp_q.push_back(fifo_q[0]);
        pop_req = 1; acc_total++; acc_prev = 1;
      end else acc_prev = 0;
    end
    run_m = rst;
  end

  task automatic push_word(logic [W-1:0] d);
    fifo_q.push_back(d);
    empty = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (pop_req) begin fifo_data = fifo_q.pop_front(); pop_req = 0; end
    if (refill_n > 0 && fifo_q.size() < 4) begin
      fifo_q.push_back(W'($urandom)); refill_n--;
    end
    case (rmode)
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
    if (emode) en = ($urandom_range(0, 3) != 0);
    empty = (fifo_q.size() == 0);
  endtask

  task automatic drain(int maxc);
    int c = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || refill_n > 0) && c < maxc) begin
      step(); c++;
    end
    last_cycles = c;
    chk("drain_timeout", c >= maxc, 0);
  endtask

  task automatic reset_pulse();
    step();
    rst = 1'b0; #1;
    chk("async_read_en", read_en, 0);
    chk("async_out_valid", out_valid, 0);
    chk("async_out_last", out_last, 0);
    chk("async_out_data", out_data, 0);
    chk("async_word_count", word_count, 0);
    repeat (3) step();
    fifo_q.delete(); empty = 1'b1; refill_n = 0;
    rst = 1'b1;
  endtask

  initial begin
    int c, base;
    repeat (3) step();
    rst = 1'b1;
    // Straight stream of 17 known words
    for (int i = 1; i <= 17; i++) push_word(W'(i));
    en = 1'b1; out_ready = 1'b1;
    drain(200);
    chk("full_rate_cycles", last_cycles <= 21, 1);
    chk("wc_17", word_count, 17);
    chk("reads_17", acc_total, 17);
    // Toggling ready
    for (int i = 0; i < 17; i++) push_word(W'($urandom));
    rmode = 1;
    drain(300);
    rmode = 0; out_ready = 1'b1;
    chk("wc_34", word_count, 34);
    // Random en/ready/refill
    rmode = 2; emode = 1; refill_n = 300;
    drain(5000);
    rmode = 0; emode = 0; en = 1'b1; out_ready = 1'b1;
    chk("wc_rand", word_count, 334);
    // en dropped right after first accepted read
    en = 1'b0; step();
    for (int i = 0; i < 8; i++) push_word(W'($urandom));
    base = acc_total; en = 1'b1; c = 0;
    while (acc_total == base && c < 20) begin step(); c++; end
    en = 1'b0;
    repeat (8) step();
    chk("en_drop_reads", (acc_total - base) <= 2, 1);
    chk("en_drop_valid", out_valid, 0);
    chk("en_drop_read_en", read_en, 0);
    en = 1'b1; drain(200);
    // Reset with buffer full mid-packet
    reset_pulse();
    for (int i = 0; i < 10; i++) push_word(W'($urandom));
    en = 1'b1; out_ready = 1'b1; c = 0;
    while (xfer_total < 5 && c < 50) begin step(); c++; end
    out_ready = 1'b0;
    repeat (4) step();
    chk("pre_rst_valid", out_valid, 1);
    reset_pulse();
    for (int i = 0; i < 17; i++) push_word(W'($urandom));
    out_ready = 1'b1;
    drain(200);
    chk("post_rst_wc", word_count, 17);
    // Empty FIFO held
    repeat (20) step();
    chk("empty_read_en", read_en, 0);
    chk("empty_valid", out_valid, 0);
    // word_count wrap
    reset_pulse();
    refill_n = 65537; en = 1'b1; out_ready = 1'b1;
    drain(70000);
    chk("wc_wrap", word_count, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
